float_acc_12: RTL and testbench

- Streaming accumulator for 12-bit floats, placed directly downstream of the 12-bit float multiplier.
- Sums a window of products, delimited by last_i, into one 12-bit float result. This forms the add half of a neuron MAC.
- Output uses a valid/ready handshake toward the activation stage.
- Format matches the multiplier: bit 11 sign, bits 10:6 exponent (bias 15), bits 5:0 mantissa with hidden 1.

---
 rtl/float_acc_12_if.sv | 33 +++
 rtl/float_acc_12.sv | 157 +++++++++++++++
 tb/tb_float_acc_12.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/float_acc_12_if.sv
// Term-in / sum-out bundle for float_acc_12. With FLOAT_ACC_OVF_FLAG_EN defined
// it also carries the per-window overflow/underflow flag ovf_o.
interface float_acc_12_if #(
  parameter int CNT_W = 10
);
  logic [11:0]      data_i;
  logic             valid_i;
  logic             last_i;
  logic             ready_o;
  logic [11:0]      sum_o;
  logic             sum_valid_o;
  logic             sum_ready_i;
  logic [CNT_W-1:0] term_cnt_o;
`ifdef FLOAT_ACC_OVF_FLAG_EN
  logic             ovf_o;
`endif

  modport slave (
    input  data_i, valid_i, last_i, sum_ready_i,
    output ready_o, sum_o, sum_valid_o, term_cnt_o
`ifdef FLOAT_ACC_OVF_FLAG_EN
    , output ovf_o
`endif
  );

  modport master (
    output data_i, valid_i, last_i, sum_ready_i,
    input  ready_o, sum_o, sum_valid_o, term_cnt_o
`ifdef FLOAT_ACC_OVF_FLAG_EN
    , input ovf_o
`endif
  );
endinterface

// File: rtl/float_acc_12.sv
// Windowed accumulator for 12-bit floats (1/5/6, bias 15) feeding the activation
// stage. Optional sticky overflow flag ovf_o is enabled by FLOAT_ACC_OVF_FLAG_EN.
module float_acc_12 #(
  parameter int CNT_W = 10
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  float_acc_12_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  // Result in [11:0]; bit 12 flags saturation or a nonzero result flushed to zero.
  function automatic logic [12:0] round_sat(input logic sgn, input logic signed [7:0] e_in,
                                            input logic [6:0] mant, input logic grd);
    logic [7:0]        m8;
    logic signed [7:0] e;
    m8 = {1'b0, mant} + {7'd0, grd};
    e  = e_in;
    if (m8[7]) begin
      m8 = 8'h40;
      e  = e + 8'sd1;
    end
    if (m8[7:6] == 2'b00)   round_sat = 13'h000;
    else if (e < 8'sd1)     round_sat = {1'b1, 12'h000};
    else if (e > 8'sd31)    round_sat = {1'b1, sgn, 11'h7FF};
    else                    round_sat = {1'b0, sgn, e[4:0], m8[5:0]};
  endfunction

  function automatic logic [12:0] fadd(input logic [11:0] a, input logic [11:0] b);
    logic [11:0]       big, sml;
    logic [4:0]        d;
    logic [6:0]        sig_big, sig_sml, mant;
    logic [14:0]       sh;
    logic [8:0]        op_s;
    logic [9:0]        raw;
    logic [15:0]       wide;
    logic [3:0]        lz;
    logic              grd;
    logic signed [7:0] exp_s;
    fadd = 13'h000;
    if (a[10:6] == 5'd0 && b[10:6] == 5'd0) begin
      fadd = 13'h000;
    end else if (a[10:6] == 5'd0) begin
      fadd = {1'b0, b};
    end else if (b[10:6] == 5'd0) begin
      fadd = {1'b0, a};
    end else begin
      if (a[10:0] >= b[10:0]) begin
        big = a; sml = b;
      end else begin
        big = b; sml = a;
      end
      d       = big[10:6] - sml[10:6];
      sig_big = {1'b1, big[5:0]};
      sig_sml = {1'b1, sml[5:0]};
      // Aligned smaller operand as {int[6:0], guard, sticky}.
      sh      = {sig_sml, 8'd0} >> d;
      op_s    = (d > 5'd8) ? 9'd1 : {sh[14:8], sh[7], |sh[6:0]};
      if (big[11] == sml[11]) raw = {1'b0, sig_big, 2'b00} + {1'b0, op_s};
      else                    raw = {1'b0, sig_big, 2'b00} - {1'b0, op_s};
      exp_s = signed'({3'b000, big[10:6]});
      if (raw[9]) begin
        fadd = round_sat(big[11], exp_s + 8'sd1, raw[9:3], raw[2]);
      end else begin
        lz = 4'd0;
        for (int i = 0; i < 9; i++) if (raw[i]) lz = 4'(8 - i);
        wide        = {raw[8:0], 7'd0};
        {mant, grd} = wide[4'd15 - lz -: 8];
        fadd = round_sat(big[11], exp_s - signed'({4'd0, lz}), mant, grd);
      end
    end
  endfunction

  state_t           r_state, w_next;
  logic             r_ready;
  logic [11:0]      r_acc, r_sum;
  logic [CNT_W-1:0] r_cnt, r_term_cnt, w_cnt_inc;
  logic             r_sum_valid;
  logic             w_accept, w_last;
  logic [12:0]      w_fadd;

  assign w_accept  = bus.valid_i & r_ready;
  assign w_last    = w_accept & bus.last_i;
  assign w_fadd    = fadd(r_acc, bus.data_i);
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = bus.last_i ? HOLD : ACC;
      ACC:     if (w_last) w_next = HOLD;
      HOLD:    if (r_sum_valid && bus.sum_ready_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next != HOLD);
    end
  end

  // Accumulate / result register stage
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_acc       <= 12'h000;
      r_cnt       <= '0;
      r_sum       <= 12'h000;
      r_term_cnt  <= '0;
      r_sum_valid <= 1'b0;
    end else if (w_last) begin
      r_sum       <= w_fadd[11:0];
      r_term_cnt  <= w_cnt_inc;
      r_sum_valid <= 1'b1;
      r_acc       <= 12'h000;
      r_cnt       <= '0;
    end else if (w_accept) begin
      r_acc <= w_fadd[11:0];
      r_cnt <= w_cnt_inc;
    end else if (r_sum_valid && bus.sum_ready_i) begin
      r_sum_valid <= 1'b0;
    end
  end

`ifdef FLOAT_ACC_OVF_FLAG_EN
  logic r_ovf_win, r_ovf;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ovf_win <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_last) begin
      r_ovf     <= r_ovf_win | w_fadd[12];
      r_ovf_win <= 1'b0;
    end else if (w_accept) begin
      r_ovf_win <= r_ovf_win | w_fadd[12];
      if (r_state == IDLE) r_ovf <= 1'b0;
    end
  end

  assign bus.ovf_o = r_ovf;
`else
  logic w_unused_flag;
  assign w_unused_flag = w_fadd[12];
`endif

  assign bus.ready_o     = r_ready;
  assign bus.sum_o       = r_sum;
  assign bus.sum_valid_o = r_sum_valid;
  assign bus.term_cnt_o  = r_term_cnt;

endmodule

// File: tb/tb_float_acc_12.sv
// Directed bench for float_acc_12: windows with hand-computed sums, hold/backpressure
// and mid-window asynchronous reset.
module tb_float_acc_12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  float_acc_12_if #(.CNT_W(10)) bus ();

  float_acc_12 #(.CNT_W(10)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", tag, got, want);
    end
  endtask

  // Presents one term, waits (bounded) for ready, returns at #1 after the taking edge.
  task automatic send(input logic [11:0] d, input logic last);
    for (int k = 0; k < 50 && !bus.ready_o; k++) begin
      @(posedge clk); #1;
    end
    if (!bus.ready_o) chk("ready_timeout", {31'd0, bus.ready_o}, 32'd1);
    bus.data_i  = d;
    bus.last_i  = last;
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.last_i  = 1'b0;
    bus.data_i  = 12'h000;
  endtask

  task automatic take(input string tag, input logic [11:0] s, input logic [9:0] n);
    chk({tag, "_valid"}, {31'd0, bus.sum_valid_o}, 32'd1);
    chk({tag, "_sum"}, {20'd0, bus.sum_o}, {20'd0, s});
    chk({tag, "_cnt"}, {22'd0, bus.term_cnt_o}, {22'd0, n});
    bus.sum_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.sum_ready_i = 1'b0;
    chk({tag, "_vld_drop"}, {31'd0, bus.sum_valid_o}, 32'd0);
    chk({tag, "_rdy_back"}, {31'd0, bus.ready_o}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.data_i = 12'h000; bus.valid_i = 1'b0; bus.last_i = 1'b0; bus.sum_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, bus.ready_o}, 32'd0);
    chk("rst_sum", {20'd0, bus.sum_o}, 32'd0);
    chk("rst_valid", {31'd0, bus.sum_valid_o}, 32'd0);
    chk("rst_cnt", {22'd0, bus.term_cnt_o}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'd0, bus.ready_o}, 32'd1);

    // 1+1+1 = 3.0, with an idle cycle carrying a stray last_i
    send(12'h3C0, 1'b0);
    send(12'h3C0, 1'b0);
    bus.last_i = 1'b1;
    @(posedge clk); #1;
    bus.last_i = 1'b0;
    chk("w1_no_early", {31'd0, bus.sum_valid_o}, 32'd0);
    send(12'h3C0, 1'b1);
    chk("w1_ready_low", {31'd0, bus.ready_o}, 32'd0);
    take("w1", 12'h420, 10'd3);

    send(12'h3C0, 1'b0);
    send(12'hBC0, 1'b1);
    take("cancel", 12'h000, 10'd2);
`ifdef FLOAT_ACC_OVF_FLAG_EN
    chk("cancel_ovf", {31'd0, bus.ovf_o}, 32'd0);
`endif

    send(12'h3C0, 1'b0);
    send(12'h200, 1'b1);
    take("tie", 12'h3C1, 10'd2);

    // 3.0 - 1.0 = 2.0
    send(12'h420, 1'b0);
    send(12'hBC0, 1'b1);
    take("sub", 12'h400, 10'd2);

    // exponent-0 operands are zero whatever their mantissa/sign
    send(12'h83F, 1'b0);
    send(12'h3C0, 1'b0);
    send(12'h03F, 1'b1);
    take("zero_ops", 12'h3C0, 10'd3);

    send(12'h7FF, 1'b0);
    send(12'h7FF, 1'b1);
`ifdef FLOAT_ACC_OVF_FLAG_EN
    chk("sat_ovf", {31'd0, bus.ovf_o}, 32'd1);
`endif
    take("sat", 12'h7FF, 10'd2);

    send(12'h3E0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, bus.sum_valid_o}, 32'd1);
      chk("hold_sum", {20'd0, bus.sum_o}, 32'h3E0);
      chk("hold_cnt", {22'd0, bus.term_cnt_o}, 32'd1);
      chk("hold_ready", {31'd0, bus.ready_o}, 32'd0);
    end
`ifdef FLOAT_ACC_OVF_FLAG_EN
    chk("hold_ovf_cleared", {31'd0, bus.ovf_o}, 32'd0);
`endif
    take("hold", 12'h3E0, 10'd1);

    send(12'h3C0, 1'b0);
    send(12'h3C0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, bus.ready_o}, 32'd0);
    chk("mid_rst_sum", {20'd0, bus.sum_o}, 32'd0);
    chk("mid_rst_valid", {31'd0, bus.sum_valid_o}, 32'd0);
    chk("mid_rst_cnt", {22'd0, bus.term_cnt_o}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(12'h400, 1'b1);
    take("post_rst", 12'h400, 10'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
